hsv_frame_sequencer: RTL and testbench

Frame sequencer that drives the HSV-to-RGB converter to produce a rotating rainbow across a WS2812B strip. Per frame it issues one H/S/V triple per LED, waits out the converter latency and captures the GRB word. It then hands each pixel to the serial LED driver over a valid/ready handshake. After the last pixel it holds an inter-frame latch gap and advances the base hue.

---
 rtl/hsv_frame_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_hsv_frame_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hsv_frame_sequencer.sv
// Rotating-rainbow frame sequencer: issues H/S/V per LED, captures the GRB result,
// hands pixels to the LED driver, then holds the latch gap. Optional macro HSV_BREATH_EN.
module hsv_frame_sequencer #(
  parameter int unsigned NUM_LEDS       = 8,
  parameter int unsigned HUE_STEP       = 8,
  parameter int unsigned FRAME_HUE_STEP = 1,
  parameter int unsigned CONV_LATENCY   = 1,
  parameter int unsigned GAP_CYCLES     = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  sat,
  input  logic [7:0]  val,
  output logic [7:0]  h_out,
  output logic [7:0]  s_out,
  output logic [7:0]  v_out,
  input  logic [23:0] rgb_in,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned LED_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned WAIT_W = (CONV_LATENCY > 0) ? $clog2(CONV_LATENCY + 1) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         base_hue, base_hue_d;
  logic [7:0]         cur_hue, cur_hue_d;
  logic [LED_W-1:0]   led_idx, led_idx_d;
  logic [WAIT_W-1:0]  wait_cnt, wait_d;
  logic [GAP_W-1:0]   gap_cnt, gap_d;
  logic [7:0]         h_d, s_d, v_d, v_start;
  logic [23:0]        pix_data_d;
  logic               pix_valid_d, pix_last_d, busy_d, frame_done_d;
  logic               start_frame;
`ifdef HSV_BREATH_EN
  logic [7:0]         breath, breath_d;
  logic               breath_up, breath_up_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    base_hue_d   = base_hue;
    cur_hue_d    = cur_hue;
    led_idx_d    = led_idx;
    wait_d       = wait_cnt;
    gap_d        = gap_cnt;
    h_d          = h_out;
    s_d          = s_out;
    v_d          = v_out;
    pix_data_d   = pix_data;
    pix_valid_d  = pix_valid;
    pix_last_d   = pix_last;
    frame_done_d = 1'b0;
    start_frame  = 1'b0;
    v_start      = val;
`ifdef HSV_BREATH_EN
    breath_d     = breath;
    breath_up_d  = breath_up;
`endif

    case (state_q)
      IDLE: begin
        if (enable) start_frame = 1'b1;
      end
      ISSUE: begin
        wait_d  = WAIT_W'(CONV_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        wait_d = wait_cnt - WAIT_W'(1);
        if (wait_cnt <= WAIT_W'(1)) begin
          wait_d      = '0;
          pix_data_d  = rgb_in;
          pix_valid_d = 1'b1;
          pix_last_d  = (led_idx == LED_W'(NUM_LEDS - 1));
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          if (pix_last) begin
            gap_d   = GAP_W'(GAP_CYCLES);
            state_d = GAP;
          end else begin
            led_idx_d = led_idx + LED_W'(1);
            h_d       = cur_hue + 8'(HUE_STEP);
            cur_hue_d = h_d;
            state_d   = ISSUE;
          end
        end
      end
      GAP: begin
        gap_d = gap_cnt - GAP_W'(1);
        if (gap_cnt <= GAP_W'(1)) begin
          gap_d        = '0;
          frame_done_d = 1'b1;
          base_hue_d   = base_hue + 8'(FRAME_HUE_STEP);
`ifdef HSV_BREATH_EN
          // Triangle sweep: turn around on reaching either end
          if (breath_up) begin
            breath_d = breath + 8'd1;
            if (breath_d == 8'hFF) breath_up_d = 1'b0;
          end else begin
            breath_d = breath - 8'd1;
            if (breath_d == 8'h00) breath_up_d = 1'b1;
          end
`endif
          if (enable) start_frame = 1'b1;
          else        state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef HSV_BREATH_EN
    v_start = 8'(({8'd0, val} * {8'd0, breath_d}) >> 8);
`endif

    // Frame start: latch S/V and restart the hue walk from the base hue
    if (start_frame) begin
      s_d       = sat;
      v_d       = v_start;
      cur_hue_d = base_hue_d;
      h_d       = base_hue_d;
      led_idx_d = '0;
      state_d   = ISSUE;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_hue   <= '0;
      cur_hue    <= '0;
      led_idx    <= '0;
      wait_cnt   <= '0;
      gap_cnt    <= '0;
      h_out      <= '0;
      s_out      <= '0;
      v_out      <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      pix_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef HSV_BREATH_EN
      breath     <= '0;
      breath_up  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      base_hue   <= base_hue_d;
      cur_hue    <= cur_hue_d;
      led_idx    <= led_idx_d;
      wait_cnt   <= wait_d;
      gap_cnt    <= gap_d;
      h_out      <= h_d;
      s_out      <= s_d;
      v_out      <= v_d;
      pix_data   <= pix_data_d;
      pix_valid  <= pix_valid_d;
      pix_last   <= pix_last_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
`ifdef HSV_BREATH_EN
      breath     <= breath_d;
      breath_up  <= breath_up_d;
`endif
    end
  end

endmodule

// File: tb/tb_hsv_frame_sequencer.sv
// Randomized bench for hsv_frame_sequencer against a frame-level rainbow model.
module tb_hsv_frame_sequencer;

  localparam int unsigned NL  = 4;
  localparam int unsigned HS  = 64;
  localparam int unsigned FHS = 16;
  localparam int unsigned CL  = 1;
  localparam int unsigned GC  = 16;
`ifdef HSV_BREATH_EN
  localparam bit BREATH = 1'b1;
`else
  localparam bit BREATH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, pix_ready;
  logic [7:0]  sat, val, h_out, s_out, v_out;
  logic [23:0] rgb_in, pix_data;
  logic        pix_valid, pix_last, busy, frame_done;

  int checks   = 0;
  int failures = 0;
  int frame_no = 0;

  hsv_frame_sequencer #(
    .NUM_LEDS(NL), .HUE_STEP(HS), .FRAME_HUE_STEP(FHS),
    .CONV_LATENCY(CL), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sat(sat), .val(val),
    .h_out(h_out), .s_out(s_out), .v_out(v_out), .rgb_in(rgb_in),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Stand-in converter: arbitrary but distinctive GRB mapping
  function automatic logic [23:0] conv(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v);
    return {h ^ v, s, h + 8'd7};
  endfunction

  // One-cycle converter pipeline
  always @(posedge clk) rgb_in <= conv(h_out, s_out, v_out);

  // Brightness latched for the k-th frame since reset
  function automatic logic [7:0] exp_v(input logic [7:0] v, input int k);
    int b;
    if (!BREATH) return v;
    b = k % 510;
    if (b > 255) b = 510 - b;
    return 8'((int'(v) * b) / 256);
  endfunction

  function automatic logic [7:0] exp_hue(input int k, input int i);
    return 8'((k * FHS + i * HS) % 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (pix_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (pix_valid !== 1'b1) chk("valid_timeout", 32'(pix_valid), 32'd1);
  endtask

  // Runs one frame that has already been launched with sat=s, val=v.
  task automatic do_frame(input int stall_pix, input int stall_len, input bit drop_en,
                          input logic [7:0] s, input logic [7:0] v,
                          input logic [7:0] ns, input logic [7:0] nv);
    int n, stall, extra;
    logic [7:0]  hue, ev;
    logic [23:0] pd;
    ev = exp_v(v, frame_no);
    for (int i = 0; i < int'(NL); i++) begin
      wait_valid(n);
      if (i > 0) chk("pix_latency", n, CL + 1);
      hue = exp_hue(frame_no, i);
      pd  = conv(hue, s, ev);
      chk("h_out", h_out, hue);
      chk("s_out", s_out, s);
      chk("v_out", v_out, ev);
      chk("pix_data", pix_data, pd);
      chk("pix_last", pix_last, (i == int'(NL) - 1));
      chk("busy_run", busy, 1);
      if (i == 0) begin
        sat = 8'($urandom);
        val = 8'($urandom);
      end
      stall = (i == stall_pix) ? stall_len : $urandom_range(0, 2);
      pix_ready = (stall == 0);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("stall_valid", pix_valid, 1);
        chk("stall_data", pix_data, pd);
        chk("stall_h", h_out, hue);
        if (k == stall - 1) pix_ready = 1'b1;
      end
      @(negedge clk);
      chk("valid_drop", pix_valid, 0);
      pix_ready = 1'($urandom_range(0, 1));
      if (drop_en && i == 0) enable = 1'b0;
      if (i == int'(NL) - 1) begin
        sat = ns;
        val = nv;
      end
    end
    n = 0;
    extra = 0;
    while (frame_done !== 1'b1 && n < int'(GC) + 10) begin
      @(negedge clk);
      n++;
      if (pix_valid === 1'b1) extra++;
    end
    chk("gap_len", n, GC);
    chk("gap_no_pixel", extra, 0);
    frame_no++;
    chk("busy_after_gap", busy, enable);
    if (enable) chk("next_base", h_out, exp_hue(frame_no, 0));
    @(negedge clk);
    chk("done_pulse", frame_done, 0);
  endtask

  initial begin
    logic [7:0] cs, cv, ns, nv;
    int n;
    rst = 1'b1; enable = 1'b0; pix_ready = 1'b0; sat = 8'd0; val = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_h", h_out, 0);
    chk("rst_s", s_out, 0);
    chk("rst_v", v_out, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_last", pix_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Frames 0..18 back to back; 5-cycle stall on pixel 2 of frame 1; enable drops in frame 18
    cs = 8'd255; cv = 8'd255;
    sat = cs; val = cv; enable = 1'b1;
    for (int f = 0; f <= 18; f++) begin
      ns = 8'($urandom);
      nv = 8'($urandom);
      do_frame((f == 1) ? 2 : -1, 5, (f == 18), cs, cv, ns, nv);
      cs = ns;
      cv = nv;
    end
    repeat (3) @(negedge clk);
    chk("idle_stays", busy, 0);
    chk("idle_no_pixel", pix_valid, 0);

    // Asynchronous reset while a pixel is presented
    cs = 8'($urandom); cv = 8'($urandom);
    sat = cs; val = cv; enable = 1'b1;
    wait_valid(n);
    chk("pre_rst_h", h_out, exp_hue(frame_no, 0));
    #1 rst = 1'b1;
    #1;
    chk("async_valid", pix_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_h", h_out, 0);
    @(negedge clk);
    frame_no = 0;
    cs = 8'($urandom); cv = 8'($urandom);
    sat = cs; val = cv;
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      ns = 8'($urandom);
      nv = 8'($urandom);
      do_frame(-1, 0, (f == 2), cs, cv, ns, nv);
      cs = ns;
      cv = nv;
    end
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
